// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file and its
// pending-write scoreboard.
//
// Contents:
//   DATA_W, ADDR_W, NUM_REGS       register file geometry
//   PEND_W, PEND_MAX               per-register in-flight write counter
//   REG_ZERO                       hard-wired zero register number
//   reg_addr_t, reg_data_t         register number / register value types
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int PEND_W   = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam logic [PEND_W-1:0] PEND_MAX = 2'd3;
  localparam reg_addr_t         REG_ZERO = '0;

endpackage : regfile_pkg

// File: rtl/pend_counter.sv
// Saturating 2-bit up/down counter tracking the number of in-flight writes
// to one register.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous clear (pipeline flush); wins over inc/dec
//   inc          one more write issued to this register
//   dec          one write retired from this register
//   count        current number of in-flight writes
//   underflow    dec requested while count is already 0
module pend_counter
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] count,
  output logic              underflow
);

  logic [PEND_W-1:0] count_q;
  logic [PEND_W-1:0] count_d;

  // NOTE: every combinational output starts from a default so no path
  // leaves it unassigned; that is what keeps latches from being inferred.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && !dec && count_q != PEND_MAX) begin
      count_d = count_q + 1'b1;
    end else if (dec && !inc && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
    // inc and dec together leave the count unchanged.
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign underflow = dec && (count_q == '0);

endmodule : pend_counter

// File: rtl/regfile_scoreboard.sv
// 32 x 32-bit integer register file with two combinational read ports, one
// write-back port and a per-register pending-write scoreboard that stalls
// decode on RAW hazards and on WAW counter overflow.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   rs_addr/rs_data, rt_addr/rt_data read ports A and B (combinational)
//   issue_valid, issue_rs_used,
//   issue_rt_used, issue_dst         instruction presented by decode
//   stall                            instruction not accepted this cycle
//   wb_en, wb_addr, wb_data          write-back port; also retires pending
//   flush                            clears all pending counts
//   sb_err                           sticky: retire with no pending write
//
// Build option: define REGFILE_BYPASS_EN for write-through read bypass; a
// register being retired this cycle then no longer counts as a RAW hazard.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  reg_addr_t rs_addr,
  input  reg_addr_t rt_addr,
  output reg_data_t rs_data,
  output reg_data_t rt_data,
  input  logic      issue_valid,
  input  logic      issue_rs_used,
  input  logic      issue_rt_used,
  input  reg_addr_t issue_dst,
  output logic      stall,
  input  logic      wb_en,
  input  reg_addr_t wb_addr,
  input  reg_data_t wb_data,
  input  logic      flush,
  output logic      sb_err
);

  reg_data_t         regs_q [NUM_REGS];
  reg_data_t         regs_d [NUM_REGS];
  logic [PEND_W-1:0] pend   [NUM_REGS];
  logic [NUM_REGS-1:0] underflow;

  logic              wb_write;
  logic              accept;
  logic              rs_hazard, rt_hazard, waw_hazard;
  logic [PEND_W-1:0] rs_pend, rt_pend;
  logic              sb_err_q, sb_err_d;
  // Set by a flush, cleared by the next accepted issue: while set, a retire
  // of a count-0 register is a write-back of a flushed instruction, not an
  // error.
  logic              flushed_q, flushed_d;

  assign wb_write = wb_en && (wb_addr != REG_ZERO);

  // ---------------- storage ----------------
  always_comb begin
    regs_d = regs_q;
    if (wb_write) begin
      regs_d[wb_addr] = wb_data;
    end
    regs_d[0] = '0;
  end

  // NOTE: the register array is reset because software relies on all
  // registers reading 0 after reset; this is a flop array, not a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // ---------------- read ports ----------------
  always_comb begin
    rs_data = regs_q[rs_addr];
    rt_data = regs_q[rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (wb_write && wb_addr == rs_addr) rs_data = wb_data;
    if (wb_write && wb_addr == rt_addr) rt_data = wb_data;
`endif
  end

  // ---------------- scoreboard ----------------
  assign pend[0]      = '0;
  assign underflow[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
    pend_counter u_pend (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (flush),
      .inc      (accept && issue_dst == reg_addr_t'(r)),
      .dec      (wb_write && wb_addr == reg_addr_t'(r)),
      .count    (pend[r]),
      .underflow(underflow[r])
    );
  end

  // Effective pending counts seen by the RAW checks.
  always_comb begin
    rs_pend = pend[rs_addr];
    rt_pend = pend[rt_addr];
`ifdef REGFILE_BYPASS_EN
    // The retiring write is forwarded, so it no longer blocks a reader.
    if (wb_write && wb_addr == rs_addr && rs_pend != '0) rs_pend = rs_pend - 1'b1;
    if (wb_write && wb_addr == rt_addr && rt_pend != '0) rt_pend = rt_pend - 1'b1;
`endif
  end

  assign rs_hazard  = issue_rs_used && (rs_addr != REG_ZERO) && (rs_pend != '0);
  assign rt_hazard  = issue_rt_used && (rt_addr != REG_ZERO) && (rt_pend != '0);
  assign waw_hazard = (issue_dst != REG_ZERO) && (pend[issue_dst] == PEND_MAX);

  assign stall  = issue_valid && (rs_hazard || rt_hazard || waw_hazard);
  assign accept = issue_valid && !stall && !flush;

  // ---------------- error tracking ----------------
  always_comb begin
    flushed_d = flushed_q;
    if (flush) begin
      flushed_d = 1'b1;
    end else if (accept) begin
      flushed_d = 1'b0;
    end
    sb_err_d = sb_err_q || ((|underflow) && !flushed_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_err_q  <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      sb_err_q  <= sb_err_d;
      flushed_q <= flushed_d;
    end
  end

  assign sb_err = sb_err_q;

endmodule : regfile_scoreboard
